// File: rtl/arith_codec_pkg.sv
// arith_codec_pkg: types and helpers shared by the arithmetic decoder stream controller
package arith_codec_pkg;
  localparam int DEC_WORD_W = 32;
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD0, S_KICK, S_WAIT_RUN, S_RUN, S_FETCH, S_PROVIDE,
    S_REL_BITS, S_CAPTURE, S_ACK, S_REL_ACK, S_FLUSH, S_DONE
  } ctrl_state_t;
  function automatic logic [3:0] KEEP_FROM_COUNT(input logic [2:0] n);
    return n[2] ? 4'hF : 4'((5'd1 << n) - 5'd1);
  endfunction
endpackage

// File: rtl/arith_out_holdbuf.sv
// arith_out_holdbuf: newest result is held back until a successor or flush decides its tlast
module arith_out_holdbuf
  import arith_codec_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cap,
  input  logic [DEC_WORD_W-1:0] cap_data,
  input  logic [3:0]            cap_keep,
  input  logic                  flush,
  output logic                  can_cap,
  output logic                  empty,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DEC_WORD_W-1:0] m_tdata,
  output logic [3:0]            m_tkeep,
  output logic                  m_tlast
);
  logic                  held_v, pend_free, move;
  logic [DEC_WORD_W-1:0] held_d;
  logic [3:0]            held_k;
  assign pend_free = !m_tvalid || m_tready;
  assign can_cap   = !held_v || pend_free;
  assign move      = held_v && pend_free && (cap || flush);
  assign empty     = !held_v && !m_tvalid;
  // pending beat on the stream master, stable until it handshakes
  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
    end else if (move) begin
      m_tvalid <= 1'b1;
      m_tdata  <= held_d;
      m_tkeep  <= held_k;
      m_tlast  <= flush;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end
  // held word: the newest capture, released by its successor or by flush
  always_ff @(posedge clk) begin
    if (!rstn) begin
      held_v <= 1'b0;
      held_d <= '0;
      held_k <= '0;
    end else if (cap && can_cap) begin
      held_v <= 1'b1;
      held_d <= cap_data;
      held_k <= cap_keep;
    end else if (move) begin
      held_v <= 1'b0;
    end
  end
endmodule

// File: rtl/arith_decoder_stream_ctrl.sv
// arith_decoder_stream_ctrl: feeds one arithmetic decoder from a word stream and streams its results
module arith_decoder_stream_ctrl
  import arith_codec_pkg::*;
#(
  parameter int unsigned           TIMEOUT_CYCLES = 65535,
  parameter logic [DEC_WORD_W-1:0] PAD_WORD       = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_start,
  output logic                  busy,
  output logic                  done,
  output logic                  error_overrun,
  output logic                  error_timeout,
  output logic [15:0]           words_in,
  output logic [15:0]           words_out,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DEC_WORD_W-1:0] s_tdata,
  input  logic                  s_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DEC_WORD_W-1:0] m_tdata,
  output logic [3:0]            m_tkeep,
  output logic                  m_tlast,
  output logic                  dec_start,
  output logic [DEC_WORD_W-1:0] dec_input_bits,
  output logic                  dec_new_bits_provided,
  output logic                  dec_read_success,
  input  logic                  dec_idle,
  input  logic                  dec_result_ready,
  input  logic                  dec_new_bits_requested,
  input  logic [2:0]            dec_valid_output_bytes,
  input  logic [DEC_WORD_W-1:0] dec_out
);
  ctrl_state_t state, state_n;
  logic        last_seen, s_hs, m_hs, accept, pad, cap, can_cap, buf_empty, counting, tmo;
  logic [15:0] tmo_cnt;
  assign s_hs     = s_tvalid && s_tready;
  assign m_hs     = m_tvalid && m_tready;
  assign accept   = state == S_IDLE && cmd_start && dec_idle;
  assign pad      = state == S_FETCH && last_seen;
  assign cap      = state == S_CAPTURE && can_cap;
  assign counting = (state inside {S_LOAD0, S_FETCH, S_WAIT_RUN, S_PROVIDE, S_ACK})
                  || ((state inside {S_CAPTURE, S_FLUSH}) && m_tvalid && !m_tready);
  assign tmo      = TIMEOUT_CYCLES != 0 && counting && tmo_cnt == 16'(TIMEOUT_CYCLES);
  assign s_tready = (state == S_LOAD0 || (state == S_FETCH && !last_seen)) && !tmo;
  assign busy     = state != S_IDLE && state != S_DONE;
  assign done     = state == S_DONE;
  assign dec_start             = state == S_KICK;
  assign dec_new_bits_provided = state == S_PROVIDE;
  assign dec_read_success      = state == S_ACK;
  // next-state: handshakes with the stream and the decoder; a stall timeout overrides all
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:     state_n = accept ? S_LOAD0 : S_IDLE;
      S_LOAD0:    state_n = s_hs ? S_KICK : S_LOAD0;
      S_KICK:     state_n = S_WAIT_RUN;
      S_WAIT_RUN: state_n = dec_idle ? S_WAIT_RUN : S_RUN;
      S_RUN:      state_n = dec_result_ready ? S_CAPTURE :
                            dec_new_bits_requested ? S_FETCH :
                            dec_idle ? S_FLUSH : S_RUN;
      S_FETCH:    state_n = (last_seen || s_hs) ? S_PROVIDE : S_FETCH;
      S_PROVIDE:  state_n = dec_new_bits_requested ? S_PROVIDE : S_REL_BITS;
      S_REL_BITS: state_n = S_RUN;
      S_CAPTURE:  state_n = can_cap ? S_ACK : S_CAPTURE;
      S_ACK:      state_n = dec_result_ready ? S_ACK : S_REL_ACK;
      S_REL_ACK:  state_n = S_RUN;
      S_FLUSH:    state_n = buf_empty ? S_DONE : S_FLUSH;
      S_DONE:     state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
    if (tmo) state_n = S_DONE;
  end
  // state, wait timer, decoder input word, per-stream counters and sticky errors
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= S_IDLE;
      tmo_cnt        <= '0;
      last_seen      <= 1'b0;
      dec_input_bits <= '0;
      error_overrun  <= 1'b0;
      error_timeout  <= 1'b0;
      words_in       <= '0;
      words_out      <= '0;
    end else begin
      state   <= state_n;
      tmo_cnt <= (state_n != state || m_hs) ? '0 : counting ? tmo_cnt + 16'd1 : tmo_cnt;
      if (s_hs) begin
        dec_input_bits <= s_tdata;
        last_seen      <= s_tlast;
      end else if (pad) begin
        dec_input_bits <= PAD_WORD;
      end
      if (accept) begin
        last_seen     <= 1'b0;
        error_overrun <= 1'b0;
        error_timeout <= 1'b0;
        words_in      <= '0;
        words_out     <= '0;
      end else begin
        error_overrun <= error_overrun | pad;
        error_timeout <= error_timeout | tmo;
        words_in      <= words_in + 16'(s_hs && words_in != 16'hFFFF);
        words_out     <= words_out + 16'(m_hs && words_out != 16'hFFFF);
      end
    end
  end
  arith_out_holdbuf u_holdbuf (
    .clk      (clk),
    .rstn     (rstn),
    .cap      (cap),
    .cap_data (dec_out),
    .cap_keep (KEEP_FROM_COUNT(dec_valid_output_bytes)),
    .flush    (state == S_FLUSH),
    .can_cap  (can_cap),
    .empty    (buf_empty),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tlast  (m_tlast)
  );
endmodule

// File: tb/tb_arith_decoder_stream_ctrl.sv
// tb_arith_decoder_stream_ctrl: directed streams against a scripted decoder with hand-computed beats
module tb_arith_decoder_stream_ctrl;
  localparam int BND = 300;
  logic        clk, rstn, cmd_start, cmd_start_t;
  logic        busy, done, error_overrun, error_timeout;
  logic [15:0] words_in, words_out;
  logic        s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast;
  logic [31:0] s_tdata, m_tdata, dec_input_bits, dec_out;
  logic [3:0]  m_tkeep;
  logic        dec_start, dec_new_bits_provided, dec_read_success;
  logic        dec_idle, dec_result_ready, dec_new_bits_requested;
  logic [2:0]  dec_valid_output_bytes;
  logic        busy_t, done_t, error_overrun_t, error_timeout_t, s_tready_t, m_tvalid_t, m_tlast_t;
  logic [15:0] words_in_t, words_out_t;
  logic [31:0] m_tdata_t, dec_input_bits_t;
  logic [3:0]  m_tkeep_t;
  logic        dec_start_t, dec_new_bits_provided_t, dec_read_success_t;
  int          n_checks = 0, n_errs = 0, n_done = 0, stall_acks;
  logic [36:0] beats[$];
  logic [36:0] exp_q[$];

  arith_decoder_stream_ctrl dut (
    .clk(clk), .rstn(rstn), .cmd_start(cmd_start), .busy(busy), .done(done),
    .error_overrun(error_overrun), .error_timeout(error_timeout),
    .words_in(words_in), .words_out(words_out),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .dec_start(dec_start), .dec_input_bits(dec_input_bits),
    .dec_new_bits_provided(dec_new_bits_provided), .dec_read_success(dec_read_success),
    .dec_idle(dec_idle), .dec_result_ready(dec_result_ready),
    .dec_new_bits_requested(dec_new_bits_requested),
    .dec_valid_output_bytes(dec_valid_output_bytes), .dec_out(dec_out)
  );

  arith_decoder_stream_ctrl #(.TIMEOUT_CYCLES(16)) dut_t (
    .clk(clk), .rstn(rstn), .cmd_start(cmd_start_t), .busy(busy_t), .done(done_t),
    .error_overrun(error_overrun_t), .error_timeout(error_timeout_t),
    .words_in(words_in_t), .words_out(words_out_t),
    .s_tvalid(s_tvalid), .s_tready(s_tready_t), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid_t), .m_tready(m_tready), .m_tdata(m_tdata_t), .m_tkeep(m_tkeep_t), .m_tlast(m_tlast_t),
    .dec_start(dec_start_t), .dec_input_bits(dec_input_bits_t),
    .dec_new_bits_provided(dec_new_bits_provided_t), .dec_read_success(dec_read_success_t),
    .dec_idle(dec_idle), .dec_result_ready(dec_result_ready),
    .dec_new_bits_requested(dec_new_bits_requested),
    .dec_valid_output_bytes(dec_valid_output_bytes), .dec_out(dec_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // beat and done monitor, sampled just after the falling edge
  always @(negedge clk) begin
    #1;
    if (rstn && m_tvalid && m_tready) beats.push_back({m_tlast, m_tkeep, m_tdata});
    if (done) n_done++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic any_main();
    return |{busy, done, error_overrun, error_timeout, words_in, words_out, s_tready, m_tvalid,
             m_tdata, m_tkeep, m_tlast, dec_start, dec_input_bits, dec_new_bits_provided, dec_read_success};
  endfunction

  function automatic logic any_t();
    return |{busy_t, done_t, error_overrun_t, error_timeout_t, words_in_t, words_out_t, s_tready_t, m_tvalid_t,
             m_tdata_t, m_tkeep_t, m_tlast_t, dec_start_t, dec_input_bits_t, dec_new_bits_provided_t, dec_read_success_t};
  endfunction

  task automatic pulse_start();
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic l, input int gap);
    int k, hi;
    if (gap > 0) begin
      for (k = 0; k < BND && !s_tready; k++) @(negedge clk);
      check("gap_fetch_reached", k < BND, 1);
      hi = 0;
      repeat (gap) begin
        hi += int'(dec_new_bits_provided);
        @(negedge clk);
      end
      check("gap_provided_low", hi, 0);
    end
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    for (k = 0; k < BND && !s_tready; k++) @(negedge clk);
    check("s_handshake", k < BND, 1);
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic dec_begin();
    int k;
    for (k = 0; k < BND && !dec_start; k++) @(negedge clk);
    check("dec_start_seen", k < BND, 1);
    dec_idle = 1'b0;
    @(negedge clk);
    check("dec_start_one_cycle", dec_start, 0);
  endtask

  task automatic dec_request(input logic [31:0] exp);
    int k;
    dec_new_bits_requested = 1'b1;
    for (k = 0; k < BND && !dec_new_bits_provided; k++) @(negedge clk);
    check("provided_seen", k < BND, 1);
    check("input_bits", dec_input_bits, exp);
    dec_new_bits_requested = 1'b0;
    for (k = 0; k < BND && dec_new_bits_provided; k++) @(negedge clk);
    check("provided_dropped", k < BND, 1);
  endtask

  task automatic dec_result(input logic [31:0] d, input logic [2:0] n);
    int k;
    dec_out = d;
    dec_valid_output_bytes = n;
    dec_result_ready = 1'b1;
    for (k = 0; k < BND && !dec_read_success; k++) @(negedge clk);
    check("read_success_seen", k < BND, 1);
    dec_result_ready = 1'b0;
    dec_out = '0;
    for (k = 0; k < BND && dec_read_success; k++) @(negedge clk);
    check("read_success_dropped", k < BND, 1);
  endtask

  task automatic finish(input string name, input int b0, input int d0,
                        input logic [15:0] wi, input logic [15:0] wo, input logic ov);
    int k;
    for (k = 0; k < BND && n_done == d0; k++) @(negedge clk);
    check({name, "_done"}, n_done - d0, 1);
    check({name, "_busy"}, busy, 0);
    check({name, "_words_in"}, words_in, wi);
    check({name, "_words_out"}, words_out, wo);
    check({name, "_overrun"}, error_overrun, ov);
    check({name, "_timeout"}, error_timeout, 0);
    check({name, "_beats"}, beats.size() - b0, exp_q.size());
    foreach (exp_q[i]) check({name, "_beat"}, (b0 + i < beats.size()) ? beats[b0 + i] : 37'h0, exp_q[i]);
  endtask

  initial begin
    int b0, d0, k;
    rstn = 1'b0; cmd_start = 1'b0; cmd_start_t = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b1;
    dec_idle = 1'b1; dec_result_ready = 1'b0; dec_new_bits_requested = 1'b0;
    dec_valid_output_bytes = '0; dec_out = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs_zero", any_main(), 0);
    check("reset_outputs_zero_t", any_t(), 0);
    rstn = 1'b1;
    @(negedge clk);

    dec_idle = 1'b0;
    pulse_start();
    check("start_ignored_dec_busy", busy, 0);
    dec_idle = 1'b1;
    @(negedge clk);

    b0 = beats.size(); d0 = n_done;
    exp_q = '{{1'b1, 4'h3, 32'h0000_4241}};
    pulse_start();
    check("t1_busy", busy, 1);
    fork
      send_word(32'hA5A5_0001, 1'b1, 0);
      begin
        dec_begin();
        dec_result(32'h0000_4241, 3'd2);
        dec_idle = 1'b1;
      end
    join
    finish("t1", b0, d0, 16'd1, 16'd1, 1'b0);

    b0 = beats.size(); d0 = n_done;
    exp_q = '{{1'b0, 4'hF, 32'h6463_6261}, {1'b1, 4'h3, 32'h0000_6665}};
    pulse_start();
    fork
      begin
        send_word(32'h1111_1111, 1'b0, 0);
        send_word(32'h2222_2222, 1'b0, 0);
        send_word(32'h3333_3333, 1'b1, 10);
      end
      begin
        dec_begin();
        dec_request(32'h2222_2222);
        dec_result(32'h6463_6261, 3'd4);
        dec_request(32'h3333_3333);
        dec_result(32'h0000_6665, 3'd2);
        dec_idle = 1'b1;
      end
    join
    finish("t2", b0, d0, 16'd3, 16'd2, 1'b0);

    b0 = beats.size(); d0 = n_done;
    exp_q = '{{1'b1, 4'h1, 32'h0000_0071}};
    pulse_start();
    fork
      send_word(32'hDEAD_BEEF, 1'b1, 0);
      begin
        dec_begin();
        dec_request(32'h0000_0000);
        dec_result(32'h0000_0071, 3'd1);
        dec_idle = 1'b1;
      end
    join
    finish("t5", b0, d0, 16'd1, 16'd1, 1'b1);

    b0 = beats.size(); d0 = n_done;
    exp_q = '{{1'b1, 4'hF, 32'h7877_7675}};
    pulse_start();
    fork
      send_word(32'h4444_4444, 1'b1, 0);
      begin
        dec_begin();
        dec_result(32'h7877_7675, 3'd4);
        dec_idle = 1'b1;
      end
    join
    finish("t3", b0, d0, 16'd1, 16'd1, 1'b0);

    b0 = beats.size(); d0 = n_done;
    exp_q = '{{1'b0, 4'hF, 32'h0A0B_0C01}, {1'b0, 4'hF, 32'h0A0B_0C02}, {1'b1, 4'hF, 32'h0A0B_0C03}};
    m_tready = 1'b0;
    pulse_start();
    fork
      send_word(32'h5555_5555, 1'b1, 0);
      begin
        dec_begin();
        dec_result(32'h0A0B_0C01, 3'd4);
        dec_result(32'h0A0B_0C02, 3'd4);
        dec_out = 32'h0A0B_0C03;
        dec_valid_output_bytes = 3'd4;
        dec_result_ready = 1'b1;
        stall_acks = 0;
        repeat (50) begin
          stall_acks += int'(dec_read_success);
          @(negedge clk);
        end
        check("t4_no_ack_while_full", stall_acks, 0);
        check("t4_stall_valid", m_tvalid, 1);
        check("t4_stall_data", m_tdata, 32'h0A0B_0C01);
        m_tready = 1'b1;
        for (k = 0; k < BND && !dec_read_success; k++) @(negedge clk);
        check("t4_ack_after_drain", k < BND, 1);
        dec_result_ready = 1'b0;
        dec_out = '0;
        for (k = 0; k < BND && dec_read_success; k++) @(negedge clk);
        check("t4_ack_dropped", k < BND, 1);
        dec_idle = 1'b1;
      end
    join
    finish("t4", b0, d0, 16'd1, 16'd3, 1'b0);

    cmd_start_t = 1'b1;
    @(negedge clk);
    cmd_start_t = 1'b0;
    for (k = 0; k < BND && !done_t; k++) @(negedge clk);
    check("t6_load0_cycles", k, 17);
    check("t6_error_timeout", error_timeout_t, 1);
    check("t6_busy_low", busy_t, 0);
    @(negedge clk);
    check("t6_done_one_cycle", done_t, 0);
    check("t6_timeout_sticky", error_timeout_t, 1);

    m_tready = 1'b0;
    pulse_start();
    fork
      send_word(32'h6666_6666, 1'b1, 0);
      begin
        dec_begin();
        dec_result(32'h0000_00A1, 3'd4);
        dec_result(32'h0000_00A2, 3'd4);
      end
    join
    check("t7_busy_before_reset", busy, 1);
    check("t7_valid_before_reset", m_tvalid, 1);
    rstn = 1'b0;
    @(negedge clk);
    check("t7_outputs_zero", any_main(), 0);
    check("t7_outputs_zero_t", any_t(), 0);
    rstn = 1'b1;
    dec_idle = 1'b1;
    m_tready = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
